// File: rtl/conv_stream_host.sv
// conv_stream_host: host frame buffer that streams x to a conv block and collects y.
// Optional STALL_INJECT_EN adds LFSR-driven ready/valid gaps on both ports.
module conv_stream_host #(
  parameter int WIDTH = 20,
  parameter int LENX  = 20,
  parameter int LENF  = 13,
  parameter int ADDRX = 5,
  parameter int ADDRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_wr_en,
  input  logic [ADDRX-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             start,
  output logic [WIDTH-1:0] m_data_out_x,
  output logic             m_valid_x,
  input  logic             m_ready_x,
  input  logic [WIDTH-1:0] s_data_in_y,
  input  logic             s_valid_y,
  output logic             s_ready_y,
  input  logic [ADDRY-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done
);
  localparam int LENY = LENX - LENF + 1;
  localparam int YW   = $clog2(LENY + 1);
  localparam logic [ADDRX-1:0] LAST_X = ADDRX'(LENX - 1);
  localparam logic [ADDRX:0]   LENX_A = (ADDRX + 1)'(LENX);
  localparam logic [ADDRY:0]   LENY_A = (ADDRY + 1)'(LENY);
  localparam logic [YW-1:0]    LENY_C = YW'(LENY);

  typedef enum logic [2:0] {
    IDLE, FETCH, SEND, WAIT_Y, DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_buf [LENX];
  logic [WIDTH-1:0] y_buf [LENY];
  logic [ADDRX-1:0] tx_idx;
  logic [YW-1:0]    y_cnt;
  logic [WIDTH-1:0] x_q;
  logic             valid_q;
  logic             stall_x;
  logic             stall_y;
  logic             x_hs;
  logic             y_hs;

`ifdef STALL_INJECT_EN
  logic [6:0] lfsr;

  // x^7 + x^6 + 1, free-running from reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= 7'h5A;
    else        lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end

  assign stall_y = lfsr[0];
  assign stall_x = lfsr[1] && (state == SEND);
`else
  assign stall_y = 1'b0;
  assign stall_x = 1'b0;
`endif

  assign busy         = (state == FETCH) || (state == SEND) ||
                        (state == WAIT_Y);
  assign done         = (state == DONE);
  assign m_valid_x    = valid_q && !stall_x;
  assign m_data_out_x = x_q;
  assign s_ready_y    = busy && (y_cnt != LENY_C) && !stall_y;
  assign x_hs         = m_valid_x && m_ready_x;
  assign y_hs         = s_valid_y && s_ready_y;

  always_ff @(posedge clk) begin
    if (ld_wr_en && !busy && ({1'b0, ld_addr} < LENX_A))
      x_buf[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (y_hs)
      y_buf[y_cnt[ADDRY-1:0]] <= s_data_in_y;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < LENY_A) begin
      rd_data <= y_buf[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx_idx  <= '0;
      y_cnt   <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      if (y_hs)
        y_cnt <= y_cnt + 1'b1;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= FETCH;
            tx_idx <= '0;
            y_cnt  <= '0;
          end
        end
        FETCH: begin
          x_q     <= x_buf[tx_idx];
          valid_q <= 1'b1;
          state   <= SEND;
        end
        SEND: begin
          if (x_hs) begin
            if (tx_idx != LAST_X) begin
              tx_idx <= tx_idx + 1'b1;
              x_q    <= x_buf[tx_idx + 1'b1];
            end else begin
              valid_q <= 1'b0;
              state   <= (y_cnt == LENY_C) ? DONE : WAIT_Y;
            end
          end
        end
        WAIT_Y: begin
          if (y_cnt == LENY_C)
            state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
